// File: rtl/game_sequencer.sv
// Two-player grid game sequencer: READY countdown, round-robin move arbitration, collision/fruit outcome.
// Optional macro WRAP_AROUND_EN makes edge moves wrap modulo 8 instead of saturating.
module game_sequencer #(
  parameter logic [2:0]  FRUIT_X     = 3'd7,
  parameter logic [2:0]  FRUIT_Y     = 3'd0,
  parameter int unsigned READY_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       restart,
  input  logic       pac_req,
  input  logic [1:0] pac_dir,
  input  logic       ghost_req,
  input  logic [1:0] ghost_dir,
  output logic       pac_ack,
  output logic       ghost_ack,
  output logic [2:0] pac_x,
  output logic [2:0] pac_y,
  output logic [2:0] ghost_x,
  output logic [2:0] ghost_y,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [7:0] steps
);

  typedef enum logic [1:0] {StReady = 2'b00, StPlay = 2'b01, StWin = 2'b10, StLose = 2'b11} state_t;

  localparam logic [7:0] ReadyLast = 8'(READY_TICKS - 1);

  state_t     state_q;
  logic [7:0] ready_cnt;
  logic       last_pac;  // 1 when Pac-Man won the most recent grant

  // One axis of a move: dec/inc select the direction along this axis.
  function automatic logic [2:0] step_coord(input logic [2:0] v, input logic dec, input logic inc);
`ifdef WRAP_AROUND_EN
    if (dec) return v - 3'd1;
    if (inc) return v + 3'd1;
`else
    if (dec && v != 3'd0) return v - 3'd1;
    if (inc && v != 3'd7) return v + 3'd1;
`endif
    return v;
  endfunction

  logic       pac_elig, ghost_elig, pac_gnt, ghost_gnt;
  logic [2:0] pac_nx, pac_ny, ghost_nx, ghost_ny;
  logic       collide, on_fruit;

  always_comb begin
    pac_elig   = (state_q == StPlay) && pac_req && !pac_ack;
    ghost_elig = (state_q == StPlay) && ghost_req && !ghost_ack;
    pac_gnt    = pac_elig && (!ghost_elig || !last_pac);
    ghost_gnt  = ghost_elig && !pac_gnt;
    pac_nx     = pac_x;
    pac_ny     = pac_y;
    ghost_nx   = ghost_x;
    ghost_ny   = ghost_y;
    if (pac_gnt) begin
      pac_nx = step_coord(pac_x, pac_dir == 2'b10, pac_dir == 2'b11);
      pac_ny = step_coord(pac_y, pac_dir == 2'b00, pac_dir == 2'b01);
    end
    if (ghost_gnt) begin
      ghost_nx = step_coord(ghost_x, ghost_dir == 2'b10, ghost_dir == 2'b11);
      ghost_ny = step_coord(ghost_y, ghost_dir == 2'b00, ghost_dir == 2'b01);
    end
    collide  = (pac_nx == ghost_nx) && (pac_ny == ghost_ny);
    on_fruit = (pac_nx == FRUIT_X) && (pac_ny == FRUIT_Y);
  end

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StReady;
      ready_cnt <= 8'd0;
      last_pac  <= 1'b0;
      lives     <= 2'd3;
      steps     <= 8'd0;
      pac_ack   <= 1'b0;
      ghost_ack <= 1'b0;
      pac_x     <= 3'd0;
      pac_y     <= 3'd7;
      ghost_x   <= 3'd7;
      ghost_y   <= 3'd7;
    end else begin
      pac_ack   <= 1'b0;
      ghost_ack <= 1'b0;
      case (state_q)
        StReady: begin
          if (tick) begin
            if (ready_cnt >= ReadyLast) begin
              state_q   <= StPlay;
              ready_cnt <= 8'd0;
            end else begin
              ready_cnt <= ready_cnt + 8'd1;
            end
          end
        end
        StPlay: begin
          if (pac_gnt || ghost_gnt) begin
            pac_ack   <= pac_gnt;
            ghost_ack <= ghost_gnt;
            last_pac  <= pac_gnt;
            if (pac_gnt && steps != 8'd255) steps <= steps + 8'd1;
            if (collide && lives > 2'd1) begin
              lives     <= lives - 2'd1;
              state_q   <= StReady;
              ready_cnt <= 8'd0;
              pac_x     <= 3'd0;
              pac_y     <= 3'd7;
              ghost_x   <= 3'd7;
              ghost_y   <= 3'd7;
            end else begin
              pac_x   <= pac_nx;
              pac_y   <= pac_ny;
              ghost_x <= ghost_nx;
              ghost_y <= ghost_ny;
              if (collide) begin
                lives   <= 2'd0;
                state_q <= StLose;
              end else if (on_fruit) begin
                state_q <= StWin;
              end
            end
          end
        end
        default: begin
          if (restart) begin
            state_q   <= StReady;
            ready_cnt <= 8'd0;
            lives     <= 2'd3;
            steps     <= 8'd0;
            pac_x     <= 3'd0;
            pac_y     <= 3'd7;
            ghost_x   <= 3'd7;
            ghost_y   <= 3'd7;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_game_sequencer;
  logic       clk = 1'b0;
  logic       reset, tick, restart, pac_req, ghost_req;
  logic [1:0] pac_dir, ghost_dir;
  logic       pac_ack, ghost_ack;
  logic [2:0] pac_x, pac_y, ghost_x, ghost_y;
  logic [1:0] state, lives;
  logic [7:0] steps;
  int total = 0;
  int bad = 0;

  game_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .restart(restart),
    .pac_req(pac_req), .pac_dir(pac_dir), .ghost_req(ghost_req), .ghost_dir(ghost_dir),
    .pac_ack(pac_ack), .ghost_ack(ghost_ack), .pac_x(pac_x), .pac_y(pac_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .state(state), .lives(lives), .steps(steps)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ticks3();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
  endtask

  task automatic go_play();
    reset = 1'b1; cyc(); reset = 1'b0;
    ticks3();
  endtask

  // Lone request for one cycle, then an idle cycle so the next request is eligible.
  task automatic pac_move(input logic [1:0] dir, output logic ack);
    pac_req = 1'b1; pac_dir = dir; cyc(); ack = pac_ack; pac_req = 1'b0; cyc();
  endtask

  task automatic ghost_move(input logic [1:0] dir, output logic ack);
    ghost_req = 1'b1; ghost_dir = dir; cyc(); ack = ghost_ack; ghost_req = 1'b0; cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (lives !== 2'd3) begin bad++; $display("FAIL reset_lives got=%0d want=3", lives); end
    total++; if (steps !== 8'd0) begin bad++; $display("FAIL reset_steps got=%0d want=0", steps); end
    total++; if ({pac_x, pac_y, ghost_x, ghost_y} !== {3'd0, 3'd7, 3'd7, 3'd7}) begin
      bad++; $display("FAIL reset_pos got=%0d,%0d %0d,%0d want=0,7 7,7", pac_x, pac_y, ghost_x, ghost_y);
    end
    total++; if ({pac_ack, ghost_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {pac_ack, ghost_ack}); end
  endtask

  task automatic test_ready_play();
    reset = 1'b1; cyc(); reset = 1'b0;
    pac_req = 1'b1; pac_dir = 2'b00; restart = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; restart = 1'b0;
      total++; if (state !== 2'b00) begin bad++; $display("FAIL ready_hold%0d got=%0d want=0", i, state); end
      total++; if (pac_ack !== 1'b0 || pac_y !== 3'd7) begin
        bad++; $display("FAIL ready_no_grant ack=%b y=%0d want ack=0 y=7", pac_ack, pac_y);
      end
      cyc();
    end
    pac_req = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL ready_to_play got=%0d want=1", state); end
    restart = 1'b1; cyc(); restart = 1'b0;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL play_restart_ignored got=%0d want=1", state); end
  endtask

  task automatic test_round_robin();
    logic a;
    go_play();
    pac_req = 1'b1; pac_dir = 2'b00; ghost_req = 1'b1; ghost_dir = 2'b10;
    cyc();
    total++; if ({pac_ack, ghost_ack, pac_y, ghost_x} !== {1'b1, 1'b0, 3'd6, 3'd7}) begin
      bad++; $display("FAIL tie1_pac acks=%b%b py=%0d gx=%0d want 10 6 7", pac_ack, ghost_ack, pac_y, ghost_x);
    end
    pac_req = 1'b0; cyc();
    total++; if ({pac_ack, ghost_ack, ghost_x} !== {1'b0, 1'b1, 3'd6}) begin
      bad++; $display("FAIL tie1_ghost acks=%b%b gx=%0d want 01 6", pac_ack, ghost_ack, ghost_x);
    end
    ghost_req = 1'b0; cyc();
    total++; if ({pac_ack, ghost_ack} !== 2'b00) begin bad++; $display("FAIL tie1_idle acks=%b%b want 00", pac_ack, ghost_ack); end
    pac_move(2'b00, a);
    pac_req = 1'b1; pac_dir = 2'b00; ghost_req = 1'b1; ghost_dir = 2'b10;
    cyc();
    total++; if ({pac_ack, ghost_ack, pac_y, ghost_x} !== {1'b0, 1'b1, 3'd5, 3'd5}) begin
      bad++; $display("FAIL tie2_ghost acks=%b%b py=%0d gx=%0d want 01 5 5", pac_ack, ghost_ack, pac_y, ghost_x);
    end
    ghost_req = 1'b0; cyc();
    total++; if ({pac_ack, ghost_ack, pac_y} !== {1'b1, 1'b0, 3'd4}) begin
      bad++; $display("FAIL tie2_pac acks=%b%b py=%0d want 10 4", pac_ack, ghost_ack, pac_y);
    end
    pac_req = 1'b0; cyc();
    total++; if (steps !== 8'd3) begin bad++; $display("FAIL rr_steps got=%0d want=3", steps); end
  endtask

  task automatic test_edge();
    logic a;
    logic [2:0] want_py, want_gx;
`ifdef WRAP_AROUND_EN
    want_py = 3'd0; want_gx = 3'd0;
`else
    want_py = 3'd7; want_gx = 3'd7;
`endif
    go_play();
    pac_move(2'b01, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL edge_pac_ack got=%b want=1", a); end
    total++; if ({pac_x, pac_y} !== {3'd0, want_py}) begin
      bad++; $display("FAIL edge_pac_pos got=%0d,%0d want=0,%0d", pac_x, pac_y, want_py);
    end
    total++; if (steps !== 8'd1) begin bad++; $display("FAIL edge_steps got=%0d want=1", steps); end
    ghost_move(2'b11, a);
    total++; if (a !== 1'b1 || ghost_x !== want_gx) begin
      bad++; $display("FAIL edge_ghost ack=%b gx=%0d want ack=1 gx=%0d", a, ghost_x, want_gx);
    end
  endtask

  task automatic test_steps_sat();
    logic a;
    go_play();
    for (int i = 0; i < 256; i++) pac_move(i[0] ? 2'b01 : 2'b00, a);
    total++; if (steps !== 8'd255) begin bad++; $display("FAIL steps_sat got=%0d want=255", steps); end
  endtask

  task automatic test_collision();
    logic a;
    go_play();
    pac_move(2'b00, a);
    for (int i = 0; i < 7; i++) ghost_move(2'b10, a);
    total++; if (state !== 2'b01 || ghost_x !== 3'd0) begin
      bad++; $display("FAIL near_miss state=%0d gx=%0d want 1 0", state, ghost_x);
    end
    ghost_move(2'b00, a);
    total++; if ({state, lives, steps} !== {2'b00, 2'd2, 8'd1}) begin
      bad++; $display("FAIL coll1 state=%0d lives=%0d steps=%0d want 0 2 1", state, lives, steps);
    end
    total++; if ({pac_x, pac_y, ghost_x, ghost_y} !== {3'd0, 3'd7, 3'd7, 3'd7}) begin
      bad++; $display("FAIL coll1_pos got=%0d,%0d %0d,%0d want 0,7 7,7", pac_x, pac_y, ghost_x, ghost_y);
    end
    ticks3();
    for (int i = 0; i < 7; i++) ghost_move(2'b10, a);
    total++; if (state !== 2'b00 || lives !== 2'd1) begin
      bad++; $display("FAIL coll2 state=%0d lives=%0d want 0 1", state, lives);
    end
    ticks3();
    for (int i = 0; i < 7; i++) ghost_move(2'b10, a);
    total++; if (state !== 2'b11 || lives !== 2'd0) begin
      bad++; $display("FAIL coll3_lose state=%0d lives=%0d want 3 0", state, lives);
    end
    pac_move(2'b11, a);
    total++; if (a !== 1'b0 || {pac_x, ghost_x} !== {3'd0, 3'd0}) begin
      bad++; $display("FAIL lose_frozen ack=%b px=%0d gx=%0d want 0 0 0", a, pac_x, ghost_x);
    end
    restart = 1'b1; cyc(); restart = 1'b0;
    total++; if ({state, lives, steps, ghost_x} !== {2'b00, 2'd3, 8'd0, 3'd7}) begin
      bad++; $display("FAIL lose_restart state=%0d lives=%0d steps=%0d gx=%0d want 0 3 0 7", state, lives, steps, ghost_x);
    end
  endtask

  task automatic test_win();
    logic a;
    go_play();
    for (int i = 0; i < 7; i++) ghost_move(2'b00, a);
    total++; if (state !== 2'b01 || ghost_y !== 3'd0) begin
      bad++; $display("FAIL ghost_fruit state=%0d gy=%0d want 1 0", state, ghost_y);
    end
    ghost_move(2'b01, a);
    for (int i = 0; i < 7; i++) pac_move(2'b00, a);
    for (int i = 0; i < 6; i++) pac_move(2'b11, a);
    total++; if (state !== 2'b01) begin bad++; $display("FAIL pre_win got=%0d want=1", state); end
    pac_req = 1'b1; pac_dir = 2'b11; cyc(); pac_req = 1'b0;
    total++; if ({state, pac_ack, pac_x, pac_y} !== {2'b10, 1'b1, 3'd7, 3'd0}) begin
      bad++; $display("FAIL win state=%0d ack=%b pos=%0d,%0d want 2 1 7,0", state, pac_ack, pac_x, pac_y);
    end
    cyc();
    pac_move(2'b10, a);
    total++; if (a !== 1'b0 || pac_x !== 3'd7 || steps !== 8'd14) begin
      bad++; $display("FAIL win_frozen ack=%b px=%0d steps=%0d want 0 7 14", a, pac_x, steps);
    end
    restart = 1'b1; cyc(); restart = 1'b0;
    total++; if ({state, steps, pac_x, pac_y} !== {2'b00, 8'd0, 3'd0, 3'd7}) begin
      bad++; $display("FAIL win_restart state=%0d steps=%0d pos=%0d,%0d want 0 0 0,7", state, steps, pac_x, pac_y);
    end
  endtask

  task automatic test_reset_mid_move();
    logic a;
    go_play();
    pac_move(2'b00, a);
    pac_req = 1'b1; pac_dir = 2'b00; reset = 1'b1; cyc(); reset = 1'b0; pac_req = 1'b0;
    total++; if ({pac_ack, state, steps, pac_y, lives} !== {1'b0, 2'b00, 8'd0, 3'd7, 2'd3}) begin
      bad++; $display("FAIL reset_mid ack=%b state=%0d steps=%0d py=%0d lives=%0d want 0 0 0 7 3",
                      pac_ack, state, steps, pac_y, lives);
    end
    cyc();
    total++; if (pac_ack !== 1'b0) begin bad++; $display("FAIL reset_mid_ack2 got=%b want=0", pac_ack); end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; restart = 1'b0; pac_req = 1'b0; ghost_req = 1'b0;
    pac_dir = 2'b00; ghost_dir = 2'b00;
    cyc();
    test_reset();
    test_ready_play();
    test_round_robin();
    test_edge();
    test_steps_sat();
    test_collision();
    test_win();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
